// File: rtl/shift_unit_seq.sv
// Sequential ARM-style barrel shifter that performs one 1-bit step per clock.
// One operation goes through IDLE -> SHIFT -> DONE. The result registers only
// change on completion, so intermediate step values never reach the outputs.
module shift_unit_seq #(
  parameter int WIDTH = 16  // operand width, power of two in 8..64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [7:0]       amount,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out
);

  // The count must hold WIDTH+1 (LSL/LSR saturation) without wrapping.
  localparam int CW = $clog2(WIDTH + 2);

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_RRX = 3'b100;

  localparam logic [7:0] AMT_W    = 8'(WIDTH);
  localparam logic [7:0] AMT_WP1  = 8'(WIDTH + 1);
  localparam logic [7:0] ROT_MASK = 8'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  // Captured operation and working shift state
  logic [2:0]       mode_reg;
  logic [WIDTH-1:0] work_reg;
  logic             work_carry_reg;
  logic             cin_reg;
  logic [CW-1:0]    count_reg;

  // Combinational helpers
  logic             accept;
  logic             count_zero;
  logic [7:0]       rot_amt;
  logic [7:0]       n_amt;
  logic [CW-1:0]    count_load;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // Start is honoured whenever the unit is not mid-shift (IDLE or DONE).
  always_comb begin
    accept     = start && (state != SHIFT);
    count_zero = (count_reg == '0);
  end

  // Effective step count for the incoming request, saturated so that every
  // boundary case (by WIDTH, beyond WIDTH, rotate by multiples) falls out of
  // plain 1-bit stepping.
  always_comb begin
    n_amt   = 8'd0;
    rot_amt = amount & ROT_MASK;
    case (mode)
      MODE_LSL, MODE_LSR: begin
        n_amt = (amount > AMT_WP1) ? AMT_WP1 : amount;
      end
      MODE_ASR: begin
        n_amt = (amount > AMT_W) ? AMT_W : amount;
      end
      MODE_ROR: begin
        if (amount == 8'd0) begin
          n_amt = 8'd0;
        end else if (rot_amt == 8'd0) begin
          n_amt = AMT_W;
        end else begin
          n_amt = rot_amt;
        end
      end
      MODE_RRX: begin
        n_amt = 8'd1;
      end
      default: begin
        n_amt = 8'd0;
      end
    endcase
    count_load = CW'(n_amt);
  end

  // One 1-bit step of the captured operation applied to the working value.
  always_comb begin
    step_data  = work_reg;
    step_carry = work_carry_reg;
    case (mode_reg)
      MODE_LSL: begin
        step_data  = {work_reg[WIDTH-2:0], 1'b0};
        step_carry = work_reg[WIDTH-1];
      end
      MODE_LSR: begin
        step_data  = {1'b0, work_reg[WIDTH-1:1]};
        step_carry = work_reg[0];
      end
      MODE_ASR: begin
        step_data  = {work_reg[WIDTH-1], work_reg[WIDTH-1:1]};
        step_carry = work_reg[0];
      end
      MODE_ROR: begin
        step_data  = {work_reg[0], work_reg[WIDTH-1:1]};
        step_carry = work_reg[0];
      end
      MODE_RRX: begin
        step_data  = {cin_reg, work_reg[WIDTH-1:1]};
        step_carry = work_reg[0];
      end
      default: begin
        step_data  = work_reg;
        step_carry = work_carry_reg;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: SHIFT lingers one edge after the count hits zero so the
  // result is published on the edge that enters DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (count_zero) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = accept ? SHIFT : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Datapath: capture on accept, step while counting, publish on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg       <= 3'd0;
      work_reg       <= '0;
      work_carry_reg <= 1'b0;
      cin_reg        <= 1'b0;
      count_reg      <= '0;
      data_out       <= '0;
      carry_out      <= 1'b0;
    end else begin
      if (accept) begin
        mode_reg       <= mode;
        work_reg       <= data_in;
        work_carry_reg <= carry_in;
        cin_reg        <= carry_in;
        count_reg      <= count_load;
      end else if ((state == SHIFT) && !count_zero) begin
        work_reg       <= step_data;
        work_carry_reg <= step_carry;
        count_reg      <= count_reg - CW'(1);
      end
      if ((state == SHIFT) && count_zero) begin
        data_out  <= work_reg;
        carry_out <= work_carry_reg;
      end
    end
  end

endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, giving the operand width; it must be a power of two from 8 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request; sampled on rising clk.
REQ-005 The block SHALL have port mode, input, 3 bits: 000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX; 101-111 are pass-through.
REQ-006 The block SHALL have port data_in, input, WIDTH bits: operand.
REQ-007 The block SHALL have port amount, input, 8 bits: unsigned shift amount, 0-255.
REQ-008 The block SHALL have port carry_in, input, 1 bit: incoming C flag.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-011 The block SHALL have port data_out, output, WIDTH bits: shift result.
REQ-012 The block SHALL have port carry_out, output, 1 bit: shifter carry result.

Function
REQ-013 The block SHALL use FSM states IDLE, SHIFT and DONE; busy=1 only in SHIFT.
REQ-014 The block SHALL accept start only when busy=0 (IDLE or DONE), capturing mode, data_in, amount and carry_in at that edge; start while busy SHALL be ignored.
REQ-015 The block SHALL load an effective count N at acceptance, as follows:
- LSL/LSR: min(amount, WIDTH+1).
- ASR: min(amount, WIDTH).
- ROR: amount mod WIDTH; if that is 0 and amount is nonzero, N=WIDTH.
- RRX: 1.
- Pass-through or amount=0: 0.
REQ-016 In SHIFT, the block SHALL perform exactly one 1-bit shift per clock edge and decrement the count, then move to DONE on the edge after the count reaches 0.
REQ-017 Per-step behaviour SHALL be as follows:
- LSL: shift in 0; carry=old MSB.
- LSR: shift in 0; carry=old LSB.
- ASR: shift in old MSB; carry=old LSB.
- ROR: old LSB moves to MSB; carry=old LSB.
- RRX: carry_in moves to MSB; carry=old LSB.
REQ-018 If N=0, the block SHALL return result=data_in and carry_out=carry_in.
REQ-019 Latency: with start accepted at edge k, shifts SHALL occur at edges k+1..k+N, and done=1 with data_out/carry_out updated SHALL follow edge k+N+1, for exactly one cycle.
REQ-020 busy SHALL go high after edge k and low at the same edge that raises done.
REQ-021 data_out and carry_out SHALL hold the last completed result until the next done; intermediate shift values SHALL NOT appear on them.
REQ-022 start in the DONE cycle SHALL be accepted (back-to-back operation); done SHALL still be exactly one cycle wide.
REQ-023 Results SHALL match ARM barrel-shifter semantics:
- LSL/LSR by WIDTH: result 0, carry = bit 0 / bit WIDTH-1 respectively.
- LSL/LSR by more than WIDTH: result 0, carry 0.
- ASR by WIDTH or more: all bits = sign, carry = sign.
- ROR by a nonzero multiple of WIDTH: data unchanged, carry = MSB.
REQ-024 The internal counter SHALL be wide enough for WIDTH+1 without wrap-around.

Reset
REQ-025 While reset=1, the block SHALL force state IDLE, busy=0, done=0, data_out=0, carry_out=0 and internal count/operands to 0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after reset release SHALL be accepted normally.

Verification (WIDTH=16, start at edge k)
REQ-027 LSL, amount=1, data_in=0xC003, carry_in=0 -> data_out=0x8006, carry_out=1, done after edge k+2.
REQ-028 LSR, amount=16, data_in=0x8001 -> 0x0000, carry 1. LSR, amount=20, same data -> 0x0000, carry 0, done after edge k+18.
REQ-029 ASR, amount=4, data_in=0x8F00 -> 0xF8F0, carry 0. ASR, amount=40 -> 0xFFFF, carry 1, done after edge k+17.
REQ-030 ROR, amount=4, data_in=0x1234 -> 0x4123, carry 0. ROR, amount=32 -> 0x1234, carry 0, done after edge k+17. RRX, data_in=0x0001, carry_in=1 -> 0x8000, carry 1.
REQ-031 LSR, amount=0, carry_in=1, data_in=0xABCD -> 0xABCD, carry 1, done after edge k+1. A second start pulsed while busy (ASR by 8) is ignored; a start in the DONE cycle starts a new operation.
REQ-032 LSL, amount=10, reset pulsed at edge k+5 -> busy=0, data_out=0, carry_out=0, no done. A following start with LSL, amount=2, data_in=0x0001 -> 0x0004, carry 0.
